midori_round_post: RTL and testbench
====================================

Name: midori_round_post

Overview:
- Downstream neighbour of the Midori128 SubCell stage.
- Takes the 128-bit SubCell output for one round, then applies ShuffleCell, MixColumn and KeyAdd with a supplied 128-bit round key.
- Registers the result behind a valid/ready handshake and tracks the round index internally.
- On the final round it skips ShuffleCell/MixColumn and performs only the whitening KeyAdd.

Parameters:
- NR, 20, number of rounds per block; rounds 0..NR-2 are full, round NR-1 is final.
- CNT_W, 5, width of the round counter; must satisfy 2^CNT_W >= NR.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_first  input  1  beat is round 0 of a new block
- in_state  input  128  SubCell output; cell i = in_state[127-8i -: 8], column-major (cells 0-3 = column 0)
- round_key  input  128  round key (round constant already folded in), same cell layout
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_state  output  128  round result
- out_last  output  1  result is from round NR-1
- out_round  output  CNT_W  round index of the result held in out_state

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_last=0, out_state=0, out_round=0, FSM=IDLE, rnd=0; in_ready=1 once reset is released.
- Accept: a beat is accepted when in_valid && in_ready.
- Ready rule: in_ready = !out_valid || out_ready. The block is a single full-throughput register stage with latency 1 cycle.
- ShuffleCell: t[j] = s[P[j]], with P = 0,10,5,15,14,4,11,1,9,3,12,6,7,13,2,8.
- MixColumn: for each column c and row r, m[4c+r] = XOR of the other three cells of that column (matrix circ(0,1,1,1)).
- Full round (rnd < NR-1): out_state <= MixColumn(ShuffleCell(in_state)) ^ round_key.
- Final round (rnd == NR-1): out_state <= in_state ^ round_key, and out_last <= 1.
- out_round <= rnd on every accept.
- FSM IDLE:
  - An accepted beat with in_first=1 is processed as round 0; rnd becomes 1 and the FSM goes to RUN.
  - An accepted beat with in_first=0 is consumed and discarded; out_valid is not set. See the optional feature.
- FSM RUN:
  - Each accept processes round rnd and increments rnd.
  - The accept at rnd == NR-1 returns the FSM to IDLE with rnd=0.
  - An accepted beat with in_first=1 in RUN restarts the block: it is processed as round 0, rnd=1, the FSM stays in RUN, and the previous block is abandoned.
- Output hold: while out_valid && !out_ready, out_state, out_last and out_round hold stable and in_ready=0.
- Simultaneous out_ready and accept in the same cycle: the old result retires and the new one loads; out_valid stays 1.
- When out_valid is 1 and out_ready=1 with no accept, out_valid goes to 0 next cycle.
- Reset asserted mid-block: everything returns to the reset values immediately; any partial block is lost.
- NR=1: every in_first beat is a final round, and the FSM never leaves IDLE.

Optional Feature:
- Macro MIDORI_ROUND_CHK_EN.
- When defined, adds output err_seq (1 bit, reset 0). It is a sticky flag set by:
  - an IDLE accept with in_first=0, or
  - a RUN accept with in_first=1.
- err_seq is cleared only by reset. Data behaviour is unchanged.
- When undefined, the port and its logic are absent.

Test Plan:
- In-place column mix: in_first=1, in_state byte0=FF, rest 00, round_key=0 → next cycle out_valid=1, out_state bytes0..3 = 00 FF FF FF, rest 00, out_round=0, out_last=0.
- Shuffle and key add: round 0 with in_state byte1=AA, rest 00, round_key=all 01 → bytes4..6 = AB, byte7 = 01, all other bytes 01.
- Full block: NR=20, 20 back-to-back beats, out_ready=1 → 20 outputs with out_round 0..19; out_last=1 only on round 19, whose out_state = in_state ^ round_key; FSM back in IDLE, and the next in_first beat is again round 0.
- Back-pressure: out_ready=0 for 5 cycles after a result → in_ready=0, out_state stable; out_ready=1 together with in_valid → retire and load in the same cycle, no bubble, no loss.
- Protocol errors: in_first=0 beat in IDLE → discarded, out_valid stays 0, err_seq=1 if MIDORI_ROUND_CHK_EN is defined; in_first=1 at round 7 → processed as round 0, out_round=0.
- Mid-block reset: assert rst_n=0 at round 10 → out_valid=0 asynchronously; after release the first in_first beat yields out_round=0.

Source files
------------

// File: rtl/midori_round_post.sv
// Midori128 round tail: ShuffleCell, MixColumn and KeyAdd behind a one-deep valid/ready register.
// Optional MIDORI_ROUND_CHK_EN adds the sticky err_seq protocol flag.
module midori_round_post #(
  parameter int unsigned NR    = 20,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_first,
  input  logic [127:0]       in_state,
  input  logic [127:0]       round_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_state,
  output logic               out_last,
  output logic [CNT_W-1:0]   out_round
`ifdef MIDORI_ROUND_CHK_EN
  ,
  output logic               err_seq
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NR - 1);
  // Source cell for each destination cell of ShuffleCell, cell 0 in the top nibble.
  localparam logic [63:0] PERM = {4'd0, 4'd10, 4'd5, 4'd15, 4'd14, 4'd4, 4'd11, 4'd1,
                                  4'd9, 4'd3, 4'd12, 4'd6, 4'd7, 4'd13, 4'd2, 4'd8};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rnd, rnd_nxt, cur_rnd;
  logic             accept, load, is_final;

  function automatic logic [127:0] shuffle_cell(input logic [127:0] s);
    int unsigned src;
    shuffle_cell = '0;
    for (int unsigned j = 0; j < 16; j++) begin
      src = 32'(PERM[63-4*j -: 4]);
      shuffle_cell[127-8*j -: 8] = s[127-8*src -: 8];
    end
  endfunction

  function automatic logic [127:0] mix_column(input logic [127:0] t);
    logic [7:0] col_x;
    mix_column = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      col_x = t[127-32*c -: 8] ^ t[119-32*c -: 8] ^ t[111-32*c -: 8] ^ t[103-32*c -: 8];
      // XOR of the whole column minus the cell itself gives the circ(0,1,1,1) row.
      for (int unsigned r = 0; r < 4; r++)
        mix_column[127-8*(4*c+r) -: 8] = col_x ^ t[127-8*(4*c+r) -: 8];
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rnd   <= '0;
    end else begin
      state <= state_nxt;
      rnd   <= rnd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rnd_nxt   = rnd;
    if (load) begin
      if (is_final) begin
        state_nxt = IDLE;
        rnd_nxt   = '0;
      end else begin
        state_nxt = RUN;
        rnd_nxt   = cur_rnd + CNT_W'(1);
      end
    end
  end

  always_comb begin
    in_ready = !out_valid || out_ready;
    accept   = in_valid && in_ready;
    cur_rnd  = in_first ? '0 : rnd;
    load     = accept && (in_first || state == RUN);
    is_final = (cur_rnd == LAST_RND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_state <= '0;
      out_last  <= 1'b0;
      out_round <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_state <= (is_final ? in_state : mix_column(shuffle_cell(in_state))) ^ round_key;
      out_last  <= is_final;
      out_round <= cur_rnd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MIDORI_ROUND_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_seq <= 1'b0;
    else if (accept && ((state == IDLE) ? !in_first : in_first))
      err_seq <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_midori_round_post.sv
// Randomised self-checking bench for midori_round_post against a cell-level reference model.
module tb_midori_round_post;
  localparam int NR = 20;
  localparam int CNT_W = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, out_ready = 1'b0;
  logic [127:0] in_state = '0, round_key = '0;
  logic in_ready, out_valid, out_last;
  logic [127:0] out_state;
  logic [CNT_W-1:0] out_round;
`ifdef MIDORI_ROUND_CHK_EN
  logic err_seq;
`endif

  int tests_run = 0, fails = 0;

  midori_round_post #(.NR(NR), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_state(in_state), .round_key(round_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .out_last(out_last), .out_round(out_round)
`ifdef MIDORI_ROUND_CHK_EN
    , .err_seq(err_seq)
`endif
  );

  always #5 clk = ~clk;

  int P [16] = '{0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8};

  // Reference model state
  logic m_valid, m_last, m_run, m_err;
  logic [127:0] m_state;
  int m_round, m_rnd;

  function automatic logic [127:0] ref_full(input logic [127:0] s, input logic [127:0] k);
    logic [7:0] c [16];
    logic [7:0] t [16];
    logic [7:0] m;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) c[i] = s[127-8*i -: 8];
    for (int j = 0; j < 16; j++) t[j] = c[P[j]];
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++) begin
        m = 8'h00;
        for (int q = 0; q < 4; q++) if (q != row) m = m ^ t[4*col+q];
        res[127-8*(4*col+row) -: 8] = m;
      end
    return res ^ k;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_last = 0; m_run = 0; m_err = 0; m_state = '0; m_round = 0; m_rnd = 0;
  endtask

  // One clock: advance the model from the inputs present before the edge.
  task automatic cycle();
    logic acc;
    int r;
    bit proc;
    acc = in_valid && (!m_valid || out_ready);
    proc = 0; r = 0;
    if (acc) begin
      if (in_first) begin r = 0; proc = 1; if (m_run) m_err = 1; end
      else if (m_run) begin r = m_rnd; proc = 1; end
      else m_err = 1;
    end
    @(posedge clk);
    if (proc) begin
      m_valid = 1; m_round = r; m_last = (r == NR-1);
      m_state = (r == NR-1) ? (in_state ^ round_key) : ref_full(in_state, round_key);
      if (r == NR-1) begin m_run = 0; m_rnd = 0; end
      else begin m_run = 1; m_rnd = r + 1; end
    end else if (out_ready) m_valid = 0;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 0; in_valid = 0; in_first = 0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic first, input logic [127:0] s, input logic [127:0] k);
    in_valid = 1; in_first = first; in_state = s; round_key = k;
    cycle();
    in_valid = 0; in_first = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; #1;
    tests_run++; if ({out_valid, out_last} !== 2'b00 || out_state !== '0 || out_round !== '0) begin
      fails++; $display("FAIL reset_outputs: got v=%b l=%b s=%h r=%0d exp all zero", out_valid, out_last, out_state, out_round);
    end
    apply_reset();
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
`ifdef MIDORI_ROUND_CHK_EN
    tests_run++; if (err_seq !== 1'b0) begin fails++; $display("FAIL reset_err: got %b exp 0", err_seq); end
`endif
  endtask

  task automatic test_column_mix();
    logic [127:0] exp1;
    exp1 = 128'h00FFFFFF_00000000_00000000_00000000;
    out_ready = 1;
    beat(1, 128'hFF000000_00000000_00000000_00000000, '0);
    tests_run++; if (out_valid !== 1'b1 || out_state !== exp1 || out_round !== 0 || out_last !== 0) begin
      fails++; $display("FAIL column_mix: got v=%b s=%h r=%0d l=%b exp v=1 s=%h r=0 l=0", out_valid, out_state, out_round, out_last, exp1);
    end
    apply_reset(); out_ready = 1;
    exp1 = 128'h01010101_ABABAB01_01010101_01010101;
    beat(1, 128'h00AA0000_00000000_00000000_00000000, {16{8'h01}});
    tests_run++; if (out_state !== exp1 || out_round !== 0) begin
      fails++; $display("FAIL shuffle_key: got %h r=%0d exp %h r=0", out_state, out_round, exp1);
    end
  endtask

  task automatic test_full_block();
    logic [127:0] s, k;
    apply_reset(); out_ready = 1;
    for (int i = 0; i < NR; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom};
      beat(i == 0, s, k);
      tests_run++; if (out_valid !== 1'b1 || out_state !== m_state || out_round !== CNT_W'(i) || out_last !== (i == NR-1)) begin
        fails++; $display("FAIL block_r%0d: got v=%b s=%h r=%0d l=%b exp s=%h r=%0d l=%b", i, out_valid, out_state, out_round, out_last, m_state, i, i == NR-1);
      end
      if (i == NR-1) begin
        tests_run++; if (out_state !== (s ^ k)) begin fails++; $display("FAIL final_whiten: got %h exp %h", out_state, s ^ k); end
      end
    end
    cycle();
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL block_drain: got v=%b exp 0", out_valid); end
    beat(1, {$urandom, $urandom, $urandom, $urandom}, '0);
    tests_run++; if (out_round !== 0 || out_valid !== 1'b1 || out_state !== m_state) begin
      fails++; $display("FAIL block_restart: got r=%0d v=%b s=%h exp r=0 v=1 s=%h", out_round, out_valid, out_state, m_state);
    end
  endtask

  task automatic test_back_pressure();
    logic [127:0] held;
    apply_reset(); out_ready = 1;
    beat(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    held = m_state; out_ready = 0;
    in_valid = 1; in_first = 0; in_state = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      cycle();
      tests_run++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_state !== held || out_round !== 0) begin
        fails++; $display("FAIL hold_c%0d: got rdy=%b v=%b s=%h r=%0d exp rdy=0 v=1 s=%h r=0", i, in_ready, out_valid, out_state, out_round, held);
      end
    end
    out_ready = 1; #1;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b exp 1", in_ready); end
    cycle();
    tests_run++; if (out_valid !== 1'b1 || out_state !== m_state || out_round !== 1 || out_state === held) begin
      fails++; $display("FAIL retire_load: got v=%b s=%h r=%0d exp v=1 s=%h r=1", out_valid, out_state, out_round, m_state);
    end
    in_valid = 0;
  endtask

  task automatic test_protocol();
    apply_reset(); out_ready = 1;
    beat(0, {$urandom, $urandom, $urandom, $urandom}, '0);
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL idle_discard: got v=%b exp 0", out_valid); end
`ifdef MIDORI_ROUND_CHK_EN
    tests_run++; if (err_seq !== 1'b1) begin fails++; $display("FAIL err_idle: got %b exp 1", err_seq); end
`endif
    for (int i = 0; i < 7; i++) beat(i == 0, {$urandom, $urandom, $urandom, $urandom}, '0);
    tests_run++; if (out_round !== 6) begin fails++; $display("FAIL pre_restart: got r=%0d exp 6", out_round); end
    beat(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    tests_run++; if (out_round !== 0 || out_state !== m_state || out_last !== 1'b0) begin
      fails++; $display("FAIL run_restart: got r=%0d s=%h exp r=0 s=%h", out_round, out_state, m_state);
    end
    beat(0, {$urandom, $urandom, $urandom, $urandom}, '0);
    tests_run++; if (out_round !== 1) begin fails++; $display("FAIL after_restart: got r=%0d exp 1", out_round); end
  endtask

  task automatic test_mid_reset();
    apply_reset(); out_ready = 1;
    for (int i = 0; i < 10; i++) beat(i == 0, {$urandom, $urandom, $urandom, $urandom}, '0);
    in_valid = 1; in_first = 0; #2;
    rst_n = 0; #1;
    tests_run++; if (out_valid !== 1'b0 || out_round !== 0) begin
      fails++; $display("FAIL async_reset: got v=%b r=%0d exp v=0 r=0", out_valid, out_round);
    end
    apply_reset(); out_ready = 1;
    beat(0, {$urandom, $urandom, $urandom, $urandom}, '0);
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got v=%b exp 0", out_valid); end
    beat(1, {$urandom, $urandom, $urandom, $urandom}, '0);
    tests_run++; if (out_round !== 0 || out_state !== m_state) begin
      fails++; $display("FAIL post_reset_r0: got r=%0d s=%h exp r=0 s=%h", out_round, out_state, m_state);
    end
  endtask

  task automatic test_random_traffic();
    int errs = 0;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      in_first = (i == 0) || ($urandom_range(29) == 0);
      in_state = {$urandom, $urandom, $urandom, $urandom};
      round_key = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (in_ready !== (!m_valid || out_ready)) errs++;
      cycle();
      if (out_valid !== m_valid) errs++;
      else if (m_valid && (out_state !== m_state || out_round !== CNT_W'(m_round) || out_last !== m_last)) errs++;
    end
    in_valid = 0;
    tests_run++; if (errs != 0) begin fails++; $display("FAIL random_traffic: got %0d mismatching cycles exp 0", errs); end
`ifdef MIDORI_ROUND_CHK_EN
    tests_run++; if (err_seq !== m_err) begin fails++; $display("FAIL random_err: got %b exp %b", err_seq, m_err); end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_column_mix();
    test_full_block();
    test_back_pressure();
    test_protocol();
    test_mid_reset();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
